// File: rtl/audio_agc_out.sv
// Receiver audio conditioning: DC blocker, boxcar decimator, power-of-two gain, 12-bit saturation.
// Define AUDIO_AGC_EN to build the per-frame automatic gain control; otherwise gain is fixed at GAIN_INIT.
module audio_agc_out #(
    parameter int unsigned DEC       = 5,
    parameter int unsigned DC_SHIFT  = 10,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned GAIN_INIT = 4,
    parameter int unsigned PEAK_HI   = 1800,
    parameter int unsigned PEAK_LO   = 512
) (
    input  logic        clk_125k,
    input  logic        RST,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic [11:0] dout,
    output logic        dout_valid,
    output logic        clip,
    output logic [3:0]  gain,
    output logic        frame_done
);

    localparam int unsigned X_W   = 16;
    localparam int unsigned Y_W   = 17;
    localparam int unsigned ACC_W = X_W + DC_SHIFT + 1;
    localparam int unsigned SUM_W = 21;
    localparam int unsigned S_W   = 36;
    localparam int unsigned V_W   = S_W - 8;
    localparam int unsigned CNT_W = $clog2(DEC);

    logic signed [X_W-1:0]   x;
    logic signed [Y_W-1:0]   dc_fb;
    logic signed [Y_W-1:0]   y_new;
    logic signed [SUM_W-1:0] sum_y;
    logic signed [S_W-1:0]   s;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [3:0]              gain_cur;
    logic                    unused_lsb;

    logic signed [ACC_W-1:0] dc_acc_q, dc_acc_d;
    logic signed [Y_W-1:0]   y_q, y_d;
    logic                    y_vld_q, y_vld_d;
    logic [CNT_W-1:0]        dcnt_q, dcnt_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic signed [SUM_W-1:0] dec_q, dec_d;
    logic                    dec_vld_q, dec_vld_d;
    logic signed [V_W-1:0]   v_q, v_d;
    logic                    v_vld_q, v_vld_d;
    logic [11:0]             dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    clip_q, clip_d;

    assign x          = $signed(din[31:16]);
    assign unused_lsb = ^din[15:0];
    assign dc_fb      = Y_W'(dc_acc_q >>> DC_SHIFT);
    assign y_new      = Y_W'(x) - dc_fb;
    assign sum_y      = sum_q + SUM_W'(y_q);
    assign s          = S_W'(dec_q) <<< gain_cur;
    assign sat_hi     = v_q > V_W'(2047);
    assign sat_lo     = v_q < V_W'(-2048);

    // Datapath next-state: DC blocker, decimator, scaler, saturator
    always_comb begin
        dc_acc_d     = dc_acc_q;
        y_d          = y_q;
        y_vld_d      = din_valid;
        dcnt_d       = dcnt_q;
        sum_d        = sum_q;
        dec_d        = dec_q;
        dec_vld_d    = 1'b0;
        v_d          = v_q;
        v_vld_d      = dec_vld_q;
        dout_d       = dout_q;
        dout_valid_d = v_vld_q;
        clip_d       = 1'b0;

        if (din_valid) begin
            y_d      = y_new;
            dc_acc_d = dc_acc_q + ACC_W'(y_new);
        end

        if (y_vld_q) begin
            if (dcnt_q == CNT_W'(DEC - 1)) begin
                dec_d     = sum_y;
                sum_d     = '0;
                dcnt_d    = '0;
                dec_vld_d = 1'b1;
            end else begin
                sum_d  = sum_y;
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end

        if (dec_vld_q) begin
            v_d = V_W'(s >>> 8);
        end

        if (v_vld_q) begin
            clip_d = sat_hi | sat_lo;
            if (sat_hi) begin
                dout_d = 12'h7FF;
            end else if (sat_lo) begin
                dout_d = 12'h800;
            end else begin
                dout_d = v_q[11:0];
            end
        end
    end

    always_ff @(posedge clk_125k) begin
        if (RST) begin
            dc_acc_q     <= '0;
            y_q          <= '0;
            y_vld_q      <= 1'b0;
            dcnt_q       <= '0;
            sum_q        <= '0;
            dec_q        <= '0;
            dec_vld_q    <= 1'b0;
            v_q          <= '0;
            v_vld_q      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            clip_q       <= 1'b0;
        end else begin
            dc_acc_q     <= dc_acc_d;
            y_q          <= y_d;
            y_vld_q      <= y_vld_d;
            dcnt_q       <= dcnt_d;
            sum_q        <= sum_d;
            dec_q        <= dec_d;
            dec_vld_q    <= dec_vld_d;
            v_q          <= v_d;
            v_vld_q      <= v_vld_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            clip_q       <= clip_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign clip       = clip_q;

`ifdef AUDIO_AGC_EN
    localparam int unsigned PK_W   = 20;
    localparam int unsigned PK_MAX = (1 << PK_W) - 1;
    localparam int unsigned FCNT_W = $clog2(FRAME_LEN + 1);

    logic [V_W-1:0]    v_abs;
    logic [PK_W-1:0]   pk_sample;
    logic [3:0]        gain_q, gain_d;
    logic              frame_done_q, frame_done_d;
    logic [PK_W-1:0]   peak_q, peak_d;
    logic              clip_seen_q, clip_seen_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    // Magnitude of the unsaturated sample; -2^27 wraps to 2^27 when read unsigned
    assign v_abs     = v_q[V_W-1] ? V_W'(-v_q) : V_W'(v_q);
    assign pk_sample = (v_abs > V_W'(PK_MAX)) ? PK_W'(PK_MAX) : v_abs[PK_W-1:0];

    // Frame statistics; fcnt == FRAME_LEN marks the update cycle after the last strobe
    always_comb begin
        gain_d       = gain_q;
        frame_done_d = 1'b0;
        peak_d       = peak_q;
        clip_seen_d  = clip_seen_q;
        fcnt_d       = fcnt_q;

        if (fcnt_q == FCNT_W'(FRAME_LEN)) begin
            frame_done_d = 1'b1;
            peak_d       = '0;
            clip_seen_d  = 1'b0;
            fcnt_d       = '0;
            if (clip_seen_q || (peak_q >= PK_W'(PEAK_HI))) begin
                if (gain_q != 4'd0) begin
                    gain_d = gain_q - 4'd1;
                end
            end else if (peak_q < PK_W'(PEAK_LO)) begin
                if (gain_q != 4'd15) begin
                    gain_d = gain_q + 4'd1;
                end
            end
        end else if (v_vld_q) begin
            fcnt_d      = fcnt_q + FCNT_W'(1);
            clip_seen_d = clip_seen_q | sat_hi | sat_lo;
            if (pk_sample > peak_q) begin
                peak_d = pk_sample;
            end
        end
    end

    always_ff @(posedge clk_125k) begin
        if (RST) begin
            gain_q       <= 4'(GAIN_INIT);
            frame_done_q <= 1'b0;
            peak_q       <= '0;
            clip_seen_q  <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            gain_q       <= gain_d;
            frame_done_q <= frame_done_d;
            peak_q       <= peak_d;
            clip_seen_q  <= clip_seen_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign gain_cur   = gain_q;
    assign frame_done = frame_done_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^{32'(FRAME_LEN), 32'(PEAK_HI), 32'(PEAK_LO)};
    assign gain_cur   = 4'(GAIN_INIT);
    assign frame_done = 1'b0;
`endif

    assign gain = gain_cur;

endmodule

// File: tb/tb_audio_agc_out.sv
// Directed bench for audio_agc_out: single-block vectors plus cadence, DC, overload, weak-signal and reset sequences.
module tb_audio_agc_out;

    logic        clk_125k;
    logic        RST;
    logic [31:0] din;
    logic        din_valid;
    logic [11:0] dout;
    logic        dout_valid;
    logic        clip;
    logic [3:0]  gain;
    logic        frame_done;

    int total;
    int bad;
    int cyc;
    int coincide;

    typedef struct {
        int x;
        int exp_dout;
        int exp_clip;
    } vec_t;

    vec_t vecs[10];

    int fd_gain[8];
    int fd_cyc[8];
    int clips_in[8];
    int nfd;

    audio_agc_out dut (
        .clk_125k   (clk_125k),
        .RST        (RST),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .clip       (clip),
        .gain       (gain),
        .frame_done (frame_done)
    );

    initial clk_125k = 1'b0;
    always #5 clk_125k = ~clk_125k;

    task automatic tick();
        @(posedge clk_125k);
        #1;
        cyc = cyc + 1;
        if (dout_valid && frame_done) coincide = coincide + 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_x(input int x);
        din = {x[15:0], 16'hA5C3};
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        din_valid = 1'b0;
        tick();
        RST = 1'b0;
        cyc = 0;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sq(input int i, input int amp);
        return (((i / 50) % 2) == 0) ? amp : -amp;
    endfunction

    // Free-running square wave with frame_done / clip bookkeeping
    task automatic run_square(input int amp, input int ncyc);
        nfd = 0;
        for (int k = 0; k < 8; k++) begin
            fd_gain[k]  = -1;
            fd_cyc[k]   = -1;
            clips_in[k] = 0;
        end
        din_valid = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            set_x(sq(i, amp));
            tick();
            if (dout_valid && clip) clips_in[(nfd < 8) ? nfd : 7]++;
            if (frame_done) begin
                if (nfd < 8) begin
                    fd_gain[nfd] = int'(gain);
                    fd_cyc[nfd]  = cyc;
                end
                nfd = nfd + 1;
            end
        end
    endtask

    initial begin
        int n;
        int first;
        int last;
        int cnt;
        int perr;
        int first_dout;
        int first_clip;
        int last_dout;
        int strobes;

        total     = 0;
        bad       = 0;
        cyc       = 0;
        coincide  = 0;
        RST       = 1'b1;
        din       = '0;
        din_valid = 1'b0;

        vecs[0] = '{100, 31, 0};
        vecs[1] = '{-100, -31, 0};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{1000, 312, 0};
        vecs[4] = '{6000, 1871, 0};
        vecs[5] = '{-6000, -1872, 0};
        vecs[6] = '{6600, 2047, 1};
        vecs[7] = '{-6600, -2048, 1};
        vecs[8] = '{16384, 2047, 1};
        vecs[9] = '{-32768, -2048, 1};

        do_reset();
        check("rst_dout", $signed(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_clip", int'(clip), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_gain", int'(gain), 4);

        // One decimated block of DEC identical samples from a fresh reset
        for (int v = 0; v < 10; v++) begin
            do_reset();
            check($sformatf("vec%0d_rst_dout", v), $signed(dout), 0);
            din_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                set_x(vecs[v].x);
                tick();
            end
            din_valid = 1'b0;
            set_x(0);
            n = 0;
            while (!dout_valid && n < 20) begin
                tick();
                n = n + 1;
            end
            check($sformatf("vec%0d_latency", v), n, 3);
            check($sformatf("vec%0d_dout", v), $signed(dout), vecs[v].exp_dout);
            check($sformatf("vec%0d_clip", v), int'(clip), vecs[v].exp_clip);
            tick();
            check($sformatf("vec%0d_strobe_len", v), int'(dout_valid), 0);
        end

        // Cadence with din_valid held high
        do_reset();
        din_valid = 1'b1;
        set_x(1234);
        first = -1; last = -1; cnt = 0; perr = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (dout_valid) begin
                if (first < 0) first = cyc;
                else if (cyc - last != 5) perr++;
                last = cyc;
                cnt++;
            end
        end
        check("cad_first", first, 8);
        check("cad_count", cnt, 11);
        check("cad_period_err", perr, 0);

        // Cadence with din_valid toggling
        do_reset();
        first = -1; last = -1; cnt = 0; perr = 0;
        for (int i = 0; i < 100; i++) begin
            din_valid = ((i % 2) == 0);
            tick();
            if (dout_valid) begin
                if (first < 0) first = cyc;
                else if (cyc - last != 10) perr++;
                last = cyc;
                cnt++;
            end
        end
        check("tog_first", first, 12);
        check("tog_count", cnt, 9);
        check("tog_period_err", perr, 0);

        // DC removal on a constant input
        do_reset();
        din_valid = 1'b1;
        set_x(16384);
        first_dout = 99999; first_clip = -1; last_dout = 99999; strobes = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (dout_valid) begin
                if (strobes == 0) begin
                    first_dout = $signed(dout);
                    first_clip = int'(clip);
                end
                last_dout = $signed(dout);
                strobes++;
            end
        end
        check("dc_first_dout", first_dout, 2047);
        check("dc_first_clip", first_clip, 1);
        check("dc_final_small", int'(iabs(last_dout) <= 1), 1);

        // Overload: large square wave
        do_reset();
        run_square(16384, 5200);
`ifdef AUDIO_AGC_EN
        check("ovl_fd_count", nfd, 4);
        check("ovl_fd0_cyc", fd_cyc[0], 1284);
        check("ovl_fd3_cyc", fd_cyc[3], 5124);
        check("ovl_gain_fd0", fd_gain[0], 3);
        check("ovl_gain_fd1", fd_gain[1], 2);
        check("ovl_gain_fd2", fd_gain[2], 2);
        check("ovl_gain_fd3", fd_gain[3], 2);
        check("ovl_clip_frame0", int'(clips_in[0] > 0), 1);
        check("ovl_clip_frame1", int'(clips_in[1] > 0), 1);
        check("ovl_clip_frame2", clips_in[2], 0);
`else
        check("ovl_fd_count", nfd, 0);
        check("ovl_gain", int'(gain), 4);
        check("ovl_clip_persist", int'(clips_in[0] > 40), 1);
`endif

        // Weak signal: gain climbs then holds
        do_reset();
        run_square(256, 5200);
`ifdef AUDIO_AGC_EN
        check("weak_fd_count", nfd, 4);
        check("weak_fd0_cyc", fd_cyc[0], 1284);
        check("weak_fd1_cyc", fd_cyc[1], 2564);
        check("weak_gain_fd0", fd_gain[0], 5);
        check("weak_gain_fd1", fd_gain[1], 6);
        check("weak_gain_fd2", fd_gain[2], 7);
        check("weak_gain_fd3", fd_gain[3], 7);
        check("weak_gain_pre_rst", int'(gain), 7);
`else
        check("weak_fd_count", nfd, 0);
        check("weak_gain_pre_rst", int'(gain), 4);
`endif

        // Reset mid-frame with din_valid still high
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_dout", $signed(dout), 0);
        check("mid_rst_dout_valid", int'(dout_valid), 0);
        check("mid_rst_clip", int'(clip), 0);
        check("mid_rst_frame_done", int'(frame_done), 0);
        check("mid_rst_gain", int'(gain), 4);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            set_x(sq(i, 256));
            tick();
            if (dout_valid) cnt++;
        end
        check("mid_rst_quiet", cnt, 0);
        tick();
        check("mid_rst_first_strobe", int'(dout_valid), 1);

        check("fd_dv_overlap", coincide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
